// File: rtl/sample_packer_if.sv
// Output stream from the sample packer to the acquisition FIFO.
// One 16-bit word per enabled channel, moved over a valid/ready handshake.
interface sample_packer_if;
   logic [15:0] out_data;
   logic [3:0]  out_channel;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output out_data,
      output out_channel,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_channel,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/sample_packer.sv
// Divides clk into sample strobes, captures 16 channels, transposes every 16 samples
// into one word per enabled channel and streams them out in ascending channel order.
module sample_packer (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   acq_enable,
   input  logic [7:0]             clock_divisor,
   input  logic [15:0]            channel_enable,
   input  logic [15:0]            sample_in,
   sample_packer_if.master        out_if,
   output logic                   fifo_overflow
);

   function automatic logic [3:0] lowest_idx(input logic [15:0] m);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) idx = 4'(i);
         else      idx = idx;
      end
      return idx;
   endfunction

   logic [7:0]        div_q_r;
   logic [15:0]       mask_q_r;
   logic [7:0]        div_cnt_r;
   logic [3:0]        bit_idx_r;
   logic [15:0][14:0] cap_r;
   logic [15:0][15:0] buf_r;
   logic [15:0]       pend_r;
   logic              ovf_r;
   logic [15:0]       out_data_r;
   logic [3:0]        out_channel_r;
   logic              out_valid_r;

   logic              strobe_s;
   logic              complete_s;
   logic              hs_s;
   logic              free_s;
   logic              drop_s;
   logic [15:0]       pend_hs_s;
   logic [15:0]       pend_nxt_s;
   logic [15:0][15:0] block_s;
   logic [15:0][15:0] buf_nxt_s;
   logic [3:0]        nxt_ch_s;

   // Strobe, block completion and next emitter state; the emitter is free when the
   // handshake of this cycle (if any) leaves no channel pending.
   always_comb begin
      strobe_s   = acq_enable && (div_cnt_r == 8'd0);
      complete_s = strobe_s && (bit_idx_r == 4'd15);
      hs_s       = out_valid_r && out_if.out_ready;
      pend_hs_s  = pend_r;
      if (hs_s) pend_hs_s[out_channel_r] = 1'b0;
      else      pend_hs_s = pend_r;
      free_s     = (pend_hs_s == 16'h0000);
      for (int n = 0; n < 16; n++) begin
         block_s[n] = {sample_in[n], cap_r[n]};
      end
      pend_nxt_s = pend_hs_s;
      buf_nxt_s  = buf_r;
      drop_s     = 1'b0;
      if (complete_s) begin
         if (free_s) begin
            pend_nxt_s = mask_q_r;
            buf_nxt_s  = block_s;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         drop_s = 1'b0;
      end
      nxt_ch_s = lowest_idx(pend_nxt_s);
   end

   // Configuration latch, clock divider and per-channel sample capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q_r   <= 8'd0;
         mask_q_r  <= 16'h0000;
         div_cnt_r <= 8'd0;
         bit_idx_r <= 4'd0;
         cap_r     <= '0;
      end else if (!acq_enable) begin
         div_q_r   <= clock_divisor;
         mask_q_r  <= channel_enable;
         div_cnt_r <= 8'd0;
         bit_idx_r <= 4'd0;
      end else begin
         div_cnt_r <= (div_cnt_r == div_q_r) ? 8'd0 : div_cnt_r + 8'd1;
         if (strobe_s) begin
            bit_idx_r <= bit_idx_r + 4'd1;
            if (bit_idx_r != 4'd15) begin
               for (int n = 0; n < 16; n++) begin
                  cap_r[n][bit_idx_r] <= sample_in[n];
               end
            end
         end
      end
   end

   // Output buffer, pending mask, sticky overflow and registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_r         <= '0;
         pend_r        <= 16'h0000;
         ovf_r         <= 1'b0;
         out_valid_r   <= 1'b0;
         out_channel_r <= 4'd0;
         out_data_r    <= 16'h0000;
      end else begin
         buf_r         <= buf_nxt_s;
         pend_r        <= pend_nxt_s;
         ovf_r         <= ovf_r | drop_s;
         out_valid_r   <= (pend_nxt_s != 16'h0000);
         out_channel_r <= nxt_ch_s;
         out_data_r    <= (pend_nxt_s != 16'h0000) ? buf_nxt_s[nxt_ch_s] : 16'h0000;
      end
   end

   assign out_if.out_data    = out_data_r;
   assign out_if.out_channel = out_channel_r;
   assign out_if.out_valid   = out_valid_r;
   assign fifo_overflow      = ovf_r;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: a queue-based model of blocks and words is
// compared every cycle, plus literal expectations for each scenario.
module tb_sample_packer;
   logic        clk;
   logic        rst;
   logic        acq_enable;
   logic [7:0]  clock_divisor;
   logic [15:0] channel_enable;
   logic [15:0] sample_in;
   logic        fifo_overflow;

   sample_packer_if bus ();

   sample_packer dut (
      .clk            (clk),
      .rst            (rst),
      .acq_enable     (acq_enable),
      .clock_divisor  (clock_divisor),
      .channel_enable (channel_enable),
      .sample_in      (sample_in),
      .out_if         (bus),
      .fifo_overflow  (fifo_overflow)
   );

   typedef struct { logic [3:0] ch; logic [15:0] data; } exp_t;
   typedef struct { int cyc; logic [3:0] ch; logic [15:0] data; } got_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          valid_cnt = 0;
   bit          chk_on = 0;
   exp_t        exp_q[$];
   got_t        got_q[$];

   int          m_div, m_cyc, m_k;
   logic [15:0] m_mask;
   logic [15:0] m_cap [16];
   logic        m_ovf;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic setup(input logic [7:0] d, input logic [15:0] m);
      acq_enable     = 1'b0;
      clock_divisor  = d;
      channel_enable = m;
      tick();
   endtask

   // Model: a run strobes every div+1 cycles from its first cycle; each 16th strobe
   // yields one word per mask bit, accepted only if the previous block is fully sent.
   initial begin
      m_div = 0; m_cyc = 0; m_k = 0; m_mask = 16'h0000; m_ovf = 1'b0;
      for (int n = 0; n < 16; n++) m_cap[n] = 16'h0000;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            exp_q.delete();
            m_ovf = 1'b0; m_div = 0; m_mask = 16'h0000; m_cyc = 0; m_k = 0;
         end else begin
            if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
            if (!acq_enable) begin
               m_div = int'(clock_divisor); m_mask = channel_enable; m_cyc = 0; m_k = 0;
            end else begin
               if (m_cyc % (m_div + 1) == 0) begin
                  for (int n = 0; n < 16; n++) m_cap[n][m_k] = sample_in[n];
                  if (m_k == 15) begin
                     if (exp_q.size() == 0) begin
                        for (int n = 0; n < 16; n++)
                           if (m_mask[n]) exp_q.push_back('{ch: 4'(n), data: m_cap[n]});
                     end else begin
                        m_ovf = 1'b1;
                     end
                  end
                  m_k = (m_k + 1) % 16;
               end
               m_cyc++;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of accepted words.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            chk("valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               chk("channel", 32'(bus.out_channel), 32'(exp_q[0].ch));
               chk("data", 32'(bus.out_data), 32'(exp_q[0].data));
            end
            chk("overflow", 32'(fifo_overflow), 32'(m_ovf));
         end
         if (bus.out_valid === 1'b1) valid_cnt++;
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_q.push_back('{cyc: cyc, ch: bus.out_channel, data: bus.out_data});
      end
   end

   initial begin
      bit          seen;
      int          c0;
      logic [15:0] p0, p4;
      rst = 1'b1; acq_enable = 1'b0; clock_divisor = 8'd0; channel_enable = 16'h0000;
      sample_in = 16'h0000; bus.out_ready = 1'b1;
      tick(); tick();
      chk_on = 1;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_channel", 32'(bus.out_channel), 32'd0);
      chk("rst_overflow", 32'(fifo_overflow), 32'd0);
      rst = 1'b0;

      // 1: single channel, alternating samples
      setup(8'd0, 16'h0001); got_q.delete(); acq_enable = 1'b1;
      for (int k = 0; k < 32; k++) begin
         sample_in = (k % 2 == 0) ? 16'h0001 : 16'h0000;
         tick();
         if (k == 14) chk("t1_valid_before_16th", 32'(bus.out_valid), 32'd0);
         if (k == 15) chk("t1_valid_after_16th", 32'(bus.out_valid), 32'd1);
      end
      acq_enable = 1'b0; repeat (20) tick();
      chk("t1_words", 32'(got_q.size()), 32'd2);
      foreach (got_q[i]) begin
         chk("t1_channel", 32'(got_q[i].ch), 32'd0);
         chk("t1_data", 32'(got_q[i].data), 32'h5555);
      end

      // 2: two channels, divided clock
      setup(8'd3, 16'h8001); sample_in = 16'hFFFF; got_q.delete(); acq_enable = 1'b1;
      repeat (140) tick();
      acq_enable = 1'b0; repeat (10) tick();
      chk("t2_words", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk("t2_ch_a", 32'(got_q[0].ch), 32'd0);
         chk("t2_ch_b", 32'(got_q[1].ch), 32'd15);
         chk("t2_ch_c", 32'(got_q[2].ch), 32'd0);
         chk("t2_ch_d", 32'(got_q[3].ch), 32'd15);
         chk("t2_data", 32'(got_q[1].data), 32'hFFFF);
         chk("t2_consecutive", 32'(got_q[1].cyc - got_q[0].cyc), 32'd1);
         chk("t2_block_period", 32'(got_q[2].cyc - got_q[0].cyc), 32'd64);
      end

      // 3: backpressure for 10 cycles
      setup(8'd7, 16'h0003); got_q.delete(); bus.out_ready = 1'b0; acq_enable = 1'b1;
      seen = 0; c0 = 0;
      fork
         begin
            for (int k = 0; k < 200; k++) begin
               sample_in = 16'(k * 4951 + 1057);
               tick();
            end
         end
         begin
            for (int i = 0; i < 200 && !seen; i++) begin
               @(negedge clk);
               if (bus.out_valid === 1'b1) begin seen = 1; c0 = cyc; end
            end
            chk("t3_valid_seen", 32'(seen), 32'd1);
            repeat (10) tick();
            bus.out_ready = 1'b1;
         end
      join
      acq_enable = 1'b0; repeat (5) tick();
      chk("t3_words", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("t3_ch0", 32'(got_q[0].ch), 32'd0);
         chk("t3_ch0_time", 32'(got_q[0].cyc - c0), 32'd10);
         chk("t3_ch1", 32'(got_q[1].ch), 32'd1);
         chk("t3_ch1_time", 32'(got_q[1].cyc - got_q[0].cyc), 32'd1);
      end
      chk("t3_overflow", 32'(fifo_overflow), 32'd0);

      // 4A: full rate, all channels, ten blocks
      setup(8'd0, 16'hFFFF); got_q.delete(); bus.out_ready = 1'b1; acq_enable = 1'b1;
      for (int k = 0; k < 160; k++) begin
         sample_in = 16'($urandom);
         tick();
      end
      acq_enable = 1'b0; repeat (20) tick();
      chk("t4a_words", 32'(got_q.size()), 32'd160);
      chk("t4a_overflow", 32'(fifo_overflow), 32'd0);

      // 4B: half-rate ready forces a drop on the second block
      setup(8'd0, 16'hFFFF); acq_enable = 1'b1;
      for (int k = 0; k < 48; k++) begin
         sample_in = 16'($urandom);
         bus.out_ready = (k % 2 == 0);
         tick();
         if (k == 30) chk("t4b_no_ovf_yet", 32'(fifo_overflow), 32'd0);
         if (k == 31) chk("t4b_ovf_set", 32'(fifo_overflow), 32'd1);
      end
      bus.out_ready = 1'b1; acq_enable = 1'b0; repeat (40) tick();
      chk("t4b_ovf_sticky", 32'(fifo_overflow), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t4b_ovf_cleared", 32'(fifo_overflow), 32'd0);

      // 5: partial block discarded, second run starts at bit 0
      setup(8'd2, 16'h0011); got_q.delete(); sample_in = 16'hFFFF; acq_enable = 1'b1;
      repeat (21) tick();
      acq_enable = 1'b0; sample_in = 16'h0000; repeat (3) tick();
      acq_enable = 1'b1; p0 = 16'h00F0; p4 = 16'h1234;
      for (int c = 0; c < 48; c++) begin
         sample_in = 16'h0000;
         sample_in[0] = p0[c / 3];
         sample_in[4] = p4[c / 3];
         tick();
      end
      acq_enable = 1'b0; repeat (10) tick();
      chk("t5_words", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("t5_ch_a", 32'(got_q[0].ch), 32'd0);
         chk("t5_data_a", 32'(got_q[0].data), 32'h00F0);
         chk("t5_ch_b", 32'(got_q[1].ch), 32'd4);
         chk("t5_data_b", 32'(got_q[1].data), 32'h1234);
      end

      // 6A: reset while a 4-channel block is being emitted
      setup(8'd0, 16'h000F); acq_enable = 1'b1;
      for (int k = 0; k < 16; k++) begin
         sample_in = 16'($urandom);
         tick();
      end
      acq_enable = 1'b0; tick();
      chk("t6a_mid_emission", 32'(bus.out_valid), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6a_valid_after_rst", 32'(bus.out_valid), 32'd0);
      chk("t6a_ovf_after_rst", 32'(fifo_overflow), 32'd0);

      // 6B: empty mask never produces a word
      setup(8'd0, 16'h0000); valid_cnt = 0; acq_enable = 1'b1;
      repeat (40) tick();
      acq_enable = 1'b0; tick();
      chk("t6b_valid_cycles", 32'(valid_cnt), 32'd0);
      chk("t6b_overflow", 32'(fifo_overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
